// File: rtl/instr_fetch_unit.sv
// Instruction fetch: walks a word PC through synchronous-read imem,
// buffers {instr, pc} in a 2-entry FIFO and redirects on taken branches.
module instr_fetch_unit #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int OFFSET_WIDTH = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    output logic                    imem_rd_en,
    output logic [ADDR_WIDTH-1:0]   imem_addr,
    input  logic [DATA_WIDTH-1:0]   imem_rdata,
    output logic [DATA_WIDTH-1:0]   instr,
    output logic [ADDR_WIDTH-1:0]   instr_pc,
    output logic                    instr_valid,
    input  logic                    instr_ready,
    input  logic                    branch_taken,
    input  logic [ADDR_WIDTH-1:0]   branch_pc,
    input  logic [OFFSET_WIDTH-1:0] branch_offset,
    output logic                    busy
);

    localparam int SW = (ADDR_WIDTH > OFFSET_WIDTH) ?
                        ADDR_WIDTH : OFFSET_WIDTH;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] inflight_pc;
    logic                  inflight;
    logic                  drop;

    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic [ADDR_WIDTH-1:0] fifo_pc   [2];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            count;
    logic [1:0]            occ;

    logic                  redirect;
    logic                  push;
    logic                  pop;

    logic [SW-1:0]         off_ext;
    logic [SW-1:0]         tgt_full;
    logic [ADDR_WIDTH-1:0] tgt_pc;

    // Branch target: branch_pc + 1 + signed offset, wrapped to PC width
    always_comb begin
        off_ext  = SW'($signed(branch_offset));
        tgt_full = SW'(branch_pc) + SW'(1) + off_ext;
        tgt_pc   = tgt_full[ADDR_WIDTH-1:0];
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state, read issue and redirect decisions
    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        imem_rd_en = 1'b0;
        redirect   = 1'b0;
        occ        = count + {1'b0, inflight};
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy       = 1'b1;
                redirect   = branch_taken;
                imem_rd_en = (occ < 2'd2) && !branch_taken;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FIFO head and handshake terms
    always_comb begin
        instr_valid = (count != 2'd0);
        instr       = instr_valid ? fifo_data[rd_ptr] : '0;
        instr_pc    = instr_valid ? fifo_pc[rd_ptr]   : '0;
        imem_addr   = pc;
        pop         = instr_valid && instr_ready;
        push        = inflight && !drop && !redirect;
    end

    // PC, in-flight tracking and FIFO storage
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc          <= '0;
            inflight_pc <= '0;
            inflight    <= 1'b0;
            drop        <= 1'b0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else if (state == IDLE) begin
            if (start) pc <= '0;
        end else if (redirect) begin
            pc       <= tgt_pc;
            drop     <= inflight;
            inflight <= 1'b0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
        end else begin
            drop     <= 1'b0;
            inflight <= imem_rd_en;
            if (imem_rd_en) begin
                pc          <= pc + 1'b1;
                inflight_pc <= pc;
            end
            if (push) begin
                fifo_data[wr_ptr] <= imem_rdata;
                fifo_pc[wr_ptr]   <= inflight_pc;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Reader side of the CPU instruction memory: walks a word-addressed PC through the program image and reads instructions from synchronous-read instruction RAM.
- Presents instructions with their PC to decode over a valid/ready handshake.
- Redirects on taken branches (beq-style signed word offset), so memory loading and instruction fetch are decoupled from the core datapath.
- Sits between instruction memory and the decode stage of CPU.

Parameters:
- ADDR_WIDTH, 8, instruction RAM word-address width; PC width.
- DATA_WIDTH, 32, instruction word width.
- OFFSET_WIDTH, 16, branch immediate width (sign-extended).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; 0 clears all state.
- start  in  1  level; sampled in IDLE to begin fetching at PC 0.
- imem_rd_en  out  1  read strobe to instruction RAM.
- imem_addr  out  ADDR_WIDTH  read word address (equals PC).
- imem_rdata  in  DATA_WIDTH  RAM data, valid one cycle after a rd_en cycle.
- instr  out  DATA_WIDTH  instruction at FIFO head.
- instr_pc  out  ADDR_WIDTH  word address of instr.
- instr_valid  out  1  instr/instr_pc valid.
- instr_ready  in  1  decode accepts head this cycle.
- branch_taken  in  1  one-cycle redirect request from execute.
- branch_pc  in  ADDR_WIDTH  PC of the taken branch.
- branch_offset  in  OFFSET_WIDTH  signed word offset.
- busy  out  1  1 while in RUN.

Behaviour:
- States:
  - IDLE: no reads issued. start=1 at an edge moves to RUN with PC=0; start is ignored in RUN.
  - RUN: the unit stays in RUN until reset.
- Reset values (asynchronous, reset=0): state IDLE, PC 0, imem_addr 0, imem_rd_en 0, instr 0, instr_pc 0, instr_valid 0, busy 0, FIFO empty, in-flight flag 0, drop flag 0.
- Output buffer: 2-entry FIFO of {instr, instr_pc}.
  - The head drives instr and instr_pc; instr_valid = FIFO not empty.
  - instr and instr_pc hold stable while instr_valid=1 and instr_ready=0.
- Read issue (combinational in RUN): imem_rd_en=1 when count + inflight < 2 and branch_taken=0. On an issuing edge, PC <= PC+1 and inflight <= 1.
- Read return: the cycle after an issue, imem_rdata and the issuing PC are written into the FIFO at the next edge, unless the drop flag is set.
- Latency: start sampled at edge E0 -> rd_en=1, addr=0 in cycle after E0 -> instr_valid=1 after E2 (2 cycles). Steady state: 1 instruction/cycle while instr_ready=1.
- Handshake: transfer when instr_valid and instr_ready at an edge; the head pops. A simultaneous pop and push at count=2 is not possible (issue rule); at count=1 the count stays 1.
- Branch (branch_taken=1 at an edge, RUN only):
  - Target computation: PC <= branch_pc + 1 + sign_ext(branch_offset), truncated to ADDR_WIDTH.
  - Discards: FIFO cleared; any in-flight read is marked dropped and its data discarded; no read issued that cycle.
  - Restart: first read at the target occurs in the next cycle; instr_valid is 0 for at least 2 cycles.
  - A handshake on the same edge counts as accepted by decode; the branch still clears the rest.
- branch_taken in IDLE: ignored.
- Arithmetic: PC increment and target computation are modulo 2^ADDR_WIDTH; PC 2^ADDR_WIDTH-1 wraps to 0. A negative offset past 0 also wraps.
- Self-branch: branch_offset = -1 targets branch_pc, so the loop refetches the same word indefinitely.
- Reset mid-operation: all state clears immediately, in-flight data is lost, and the unit returns to IDLE awaiting start.

Test Plan:
1. Load RAM[0..11] with the 12-word fib program; reset=0 for 5 cycles, release, start=1 for 1 cycle, instr_ready=1 -> instr_valid rises 2 cycles after start; instr_pc sequence is 0,1,2,3,4,... and instr matches RAM words, 1 per cycle.
2. instr_ready toggles 1,0,0,1,0,1 -> no duplicated or skipped PCs; instr stays stable while stalled; imem_rd_en never issues when count + inflight = 2.
3. branch_taken with branch_pc=9, offset=0xFFFA -> next rd_en addr=4; in-flight word at 10 and FIFO contents are discarded; the next delivered instr_pc=4.
4. branch_taken with branch_pc=4, offset=5 -> target 10, delivered instr_pc=10 (RAM[10]); then branch_pc=11, offset=0xFFFF -> instr_pc=11 repeats across successive branches.
5. Let PC run to 255 with ADDR_WIDTH=8 -> next instr_pc=0; branch_pc=0, offset=-2 -> target 255.
6. Assert reset=0 mid-stream with count=2 and a read in flight -> all outputs 0 immediately; after release with no start, imem_rd_en stays 0; a new start resumes at PC 0.
